rab_slice_cfg: RTL and testbench

Configuration writer for the RAB slice array. It accepts 64-bit register writes over a valid/ready port and holds the live per-slice configuration words that the slice lookup consumes. Each slice has 4 words: min, max, offset and flags. Words 0..2 of a slice are staged and are committed atomically by the flags-word write, so the lookup never sees a half-updated slice. A one-cycle-latency read port returns live values to the host.

---
 rtl/rab_slice_cfg.sv | 199 +++++++++++++++++++
 tb/tb_rab_slice_cfg.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rab_slice_cfg.sv
// rab_slice_cfg: 64-bit configuration register file feeding the RAB slice lookup.
// Optional feature macro RAB_SLICE_CFG_STAGING_EN: min/max/offset are staged and committed atomically by the flags write.
module rab_slice_cfg #(
   parameter int N_SLICES        = 16,
   parameter int N_REGS          = 4*N_SLICES,
   parameter int ADDR_WIDTH_PHYS = 40,
   parameter int ADDR_WIDTH_VIRT = 32
) (
   input  logic                    Clk_CI,
   input  logic                    Rst_RBI,
   input  logic                    wr_valid_i,
   output logic                    wr_ready_o,
   input  logic [$clog2(N_REGS):0] wr_idx_i,
   input  logic [63:0]             wr_data_i,
   output logic                    wr_err_o,
   input  logic                    rd_valid_i,
   input  logic [$clog2(N_REGS):0] rd_idx_i,
   output logic                    rd_valid_o,
   output logic [63:0]             rd_data_o,
   input  logic                    clear_i,
   output logic [N_REGS-1:0][63:0] cfg_regs_o
);
   localparam int               IDX_W     = $clog2(N_REGS) + 1;
   localparam int               SL_W      = IDX_W - 2;
   localparam logic [IDX_W-1:0] LP_N_REGS = IDX_W'(N_REGS);

   logic                    w_wr_hs;
   logic                    w_wr_in_range;
   logic                    w_rd_in_range;
   logic [1:0]              w_wr_word;
   logic [SL_W-1:0]         w_wr_slice;
   logic [63:0]             w_wr_masked;
   wire  [N_REGS-1:0][63:0] w_cfg;

   logic                    r_wr_err;
   logic                    r_rd_valid;
   logic [63:0]             r_rd_data;

   // Bits kept per word type; everything outside the mask is stored as 0.
   function automatic logic [63:0] f_word_mask(input logic [1:0] word);
      logic [63:0] m;
      m = '0;
      case (word)
         2'd0, 2'd1: m[ADDR_WIDTH_VIRT-1:0] = '1;
         2'd2:       m[ADDR_WIDTH_PHYS-1:0] = '1;
         default:    m[3:0]                 = '1;
      endcase
      return m;
   endfunction

   assign w_wr_word     = wr_idx_i[1:0];
   assign w_wr_slice    = wr_idx_i[IDX_W-1:2];
   assign w_wr_in_range = (wr_idx_i < LP_N_REGS);
   assign w_rd_in_range = (rd_idx_i < LP_N_REGS);
   assign w_wr_masked   = wr_data_i & f_word_mask(w_wr_word);
   assign w_wr_hs       = wr_valid_i && wr_ready_o;

`ifdef RAB_SLICE_CFG_STAGING_EN
   typedef enum logic {
      S_IDLE,
      S_COMMIT
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [SL_W-1:0] r_commit_slice;
   logic [3:0]      r_commit_flags;
   logic            w_flags_wr;

   // Ready depends only on state, so the flags decode may use wr_valid_i directly.
   assign w_flags_wr = wr_valid_i && w_wr_in_range && (w_wr_word == 2'd3);

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         r_state        <= S_IDLE;
         r_commit_slice <= '0;
         r_commit_flags <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_wr_hs && w_flags_wr) begin
            r_commit_slice <= w_wr_slice;
            r_commit_flags <= w_wr_masked[3:0];
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      wr_ready_o   = 1'b0;
      case (r_state)
         S_IDLE: begin
            wr_ready_o = 1'b1;
            if (w_flags_wr) begin
               w_state_next = S_COMMIT;
            end
         end
         S_COMMIT: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end
`else
   assign wr_ready_o = 1'b1;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < N_SLICES; gi++) begin : g_slice
         logic [3:0][63:0] r_live;
         logic             w_sel;

         assign w_sel = w_wr_hs && w_wr_in_range && (w_wr_slice == SL_W'(gi));

`ifdef RAB_SLICE_CFG_STAGING_EN
         logic [2:0][63:0] r_stage;
         logic [2:0]       r_staged;
         logic             w_commit;

         assign w_commit = (r_state == S_COMMIT) && (r_commit_slice == SL_W'(gi));

         // No write can be accepted while committing, so the two branches never collide.
         always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
            if (!Rst_RBI) begin
               r_stage  <= '0;
               r_staged <= '0;
            end else if (w_commit) begin
               r_staged <= '0;
            end else if (w_sel) begin
               for (int k = 0; k < 3; k++) begin
                  if (w_wr_word == 2'(k)) begin
                     r_stage[k]  <= w_wr_masked;
                     r_staged[k] <= 1'b1;
                  end
               end
            end
         end

         always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
            if (!Rst_RBI) begin
               r_live <= '0;
            end else begin
               if (w_commit) begin
                  for (int k = 0; k < 3; k++) begin
                     if (r_staged[k]) begin
                        r_live[k] <= r_stage[k];
                     end
                  end
                  r_live[3] <= {60'd0, r_commit_flags};
               end
               // Placed last so a same-edge clear overrides the committed enable.
               if (clear_i) begin
                  r_live[3][0] <= 1'b0;
               end
            end
         end
`else
         always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
            if (!Rst_RBI) begin
               r_live <= '0;
            end else begin
               for (int k = 0; k < 4; k++) begin
                  if (w_sel && (w_wr_word == 2'(k))) begin
                     r_live[k] <= w_wr_masked;
                  end
               end
               if (clear_i) begin
                  r_live[3][0] <= 1'b0;
               end
            end
         end
`endif

         assign w_cfg[4*gi +: 4] = r_live;
      end
   endgenerate

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         r_wr_err   <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_wr_err   <= w_wr_hs && !w_wr_in_range;
         r_rd_valid <= rd_valid_i;
         if (rd_valid_i) begin
            r_rd_data <= w_rd_in_range ? w_cfg[rd_idx_i[IDX_W-2:0]] : 64'd0;
         end
      end
   end

   assign wr_err_o   = r_wr_err;
   assign rd_valid_o = r_rd_valid;
   assign rd_data_o  = r_rd_data;
   assign cfg_regs_o = w_cfg;

endmodule

// File: tb/tb_rab_slice_cfg.sv
// Scoreboard bench for rab_slice_cfg; expectations follow RAB_SLICE_CFG_STAGING_EN when defined.
module tb_rab_slice_cfg;
   localparam int N_SLICES = 16;
   localparam int N_REGS   = 4*N_SLICES;
   localparam int IDX_W    = $clog2(N_REGS) + 1;

   logic                    clk;
   logic                    Rst_RBI;
   logic                    wr_valid_i;
   logic                    wr_ready_o;
   logic [IDX_W-1:0]        wr_idx_i;
   logic [63:0]             wr_data_i;
   logic                    wr_err_o;
   logic                    rd_valid_i;
   logic [IDX_W-1:0]        rd_idx_i;
   logic                    rd_valid_o;
   logic [63:0]             rd_data_o;
   logic                    clear_i;
   logic [N_REGS-1:0][63:0] cfg_regs_o;

   int          checks   = 0;
   int          failures = 0;
   logic [63:0] exp_q[$];
   string       name_q[$];
   logic [63:0] exp_cfg[N_REGS];

   rab_slice_cfg #(
      .N_SLICES        (N_SLICES),
      .N_REGS          (N_REGS),
      .ADDR_WIDTH_PHYS (40),
      .ADDR_WIDTH_VIRT (32)
   ) dut (
      .Clk_CI     (clk),
      .Rst_RBI    (Rst_RBI),
      .wr_valid_i (wr_valid_i),
      .wr_ready_o (wr_ready_o),
      .wr_idx_i   (wr_idx_i),
      .wr_data_i  (wr_data_i),
      .wr_err_o   (wr_err_o),
      .rd_valid_i (rd_valid_i),
      .rd_idx_i   (rd_idx_i),
      .rd_valid_o (rd_valid_o),
      .rd_data_o  (rd_data_o),
      .clear_i    (clear_i),
      .cfg_regs_o (cfg_regs_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", nm, act, req);
      end else begin
         $display("ok   %s: 0x%016h", nm, act);
      end
   endtask

   task automatic chk_cfg_all(input string nm);
      int bad;
      bad = -1;
      for (int i = 0; i < N_REGS; i++) begin
         if (bad < 0 && cfg_regs_o[i] !== exp_cfg[i]) bad = i;
      end
      checks++;
      if (bad >= 0) begin
         failures++;
         $display("FAIL %s: cfg_regs_o[%0d] got 0x%016h expected 0x%016h",
                  nm, bad, cfg_regs_o[bad], exp_cfg[bad]);
      end else begin
         $display("ok   %s: all %0d live words match", nm, N_REGS);
      end
   endtask

   // Read responses are checked by the monitor as they emerge.
   always @(negedge clk) begin
      if (rd_valid_o === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL rd_unexpected: got 0x%016h with no read outstanding", rd_data_o);
         end else begin
            automatic logic [63:0] e  = exp_q.pop_front();
            automatic string       nm = name_q.pop_front();
            if (rd_data_o !== e) begin
               failures++;
               $display("FAIL %s: got 0x%016h expected 0x%016h", nm, rd_data_o, e);
            end else begin
               $display("ok   %s: 0x%016h", nm, rd_data_o);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_issue(input int idx, input logic [63:0] e, input string nm);
      rd_valid_i = 1'b1;
      rd_idx_i   = idx[IDX_W-1:0];
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic rd(input int idx, input logic [63:0] e, input string nm);
      rd_issue(idx, e, nm);
      tick();
      rd_valid_i = 1'b0;
   endtask

   task automatic wr(input int idx, input logic [63:0] d);
      int n;
      n = 0;
      wr_valid_i = 1'b1;
      wr_idx_i   = idx[IDX_W-1:0];
      wr_data_i  = d;
      while (wr_ready_o !== 1'b1 && n < 8) begin
         tick();
         n++;
      end
      if (n == 8) begin
         checks++;
         failures++;
         $display("FAIL wr_ready_timeout: idx %0d, ready stayed %b", idx, wr_ready_o);
      end
      tick();
      wr_valid_i = 1'b0;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      Rst_RBI    = 1'b0;
      wr_valid_i = 1'b0;
      wr_idx_i   = '0;
      wr_data_i  = '0;
      rd_valid_i = 1'b0;
      rd_idx_i   = '0;
      clear_i    = 1'b0;
      for (int i = 0; i < N_REGS; i++) exp_cfg[i] = 64'd0;

      // Reset state
      #3;
      chk("rst_ready", 64'(wr_ready_o), 64'd1);
      chk("rst_rd_valid", 64'(rd_valid_o), 64'd0);
      chk("rst_wr_err", 64'(wr_err_o), 64'd0);
      chk_cfg_all("rst_cfg");
      tick();
      tick();
      Rst_RBI = 1'b1;
      tick();
      for (int i = 0; i < N_REGS; i++) rd(i, 64'd0, $sformatf("rd_rst_%0d", i));
      chk("post_rst_ready", 64'(wr_ready_o), 64'd1);

      // Slice 1 programming
`ifdef RAB_SLICE_CFG_STAGING_EN
      wr(4, 64'h1000);
      wr(5, 64'h1FFF);
      wr(6, 64'hAB_0000_0000);
      chk("staged_min_not_live", cfg_regs_o[4], 64'd0);
      chk("staged_off_not_live", cfg_regs_o[6], 64'd0);
      wr(7, 64'hF);
      chk("commit_ready_low", 64'(wr_ready_o), 64'd0);
      chk("commit_flags_not_yet", cfg_regs_o[7], 64'd0);
      rd_issue(4, 64'd0, "rd_min_during_commit");
      tick();
      rd_valid_i = 1'b0;
      chk("commit_ready_back", 64'(wr_ready_o), 64'd1);
`else
      wr(4, 64'h1000);
      chk("direct_min_live", cfg_regs_o[4], 64'h1000);
      wr(5, 64'h1FFF);
      wr(6, 64'hAB_0000_0000);
      chk("direct_off_live", cfg_regs_o[6], 64'hAB_0000_0000);
      wr(7, 64'hF);
      chk("direct_ready_high", 64'(wr_ready_o), 64'd1);
      rd_issue(4, 64'h1000, "rd_min_after_write");
      tick();
      rd_valid_i = 1'b0;
`endif
      exp_cfg[4] = 64'h1000;
      exp_cfg[5] = 64'h1FFF;
      exp_cfg[6] = 64'hAB_0000_0000;
      exp_cfg[7] = 64'hF;
      chk_cfg_all("slice1_live");
      rd(6, 64'hAB_0000_0000, "rd_slice1_off");

      // Masking, flags-only update, last-write-wins
      wr(0, 64'hFFFF_FFFF_FFFF_FFFF);
      wr(2, 64'hFFFF_FFFF_FFFF_FFFF);
      wr(3, 64'h1);
      tick();
      rd(0, 64'h0000_0000_FFFF_FFFF, "rd_min_mask");
      rd(2, 64'h0000_00FF_FFFF_FFFF, "rd_off_mask");
      rd(3, 64'h1, "rd_flags0");
      wr(7, 64'hF0F3);
      tick();
      rd(7, 64'h3, "rd_flags_only");
      rd(4, 64'h1000, "rd_min_kept");
      wr(9, 64'h111);
      wr(9, 64'h222);
      wr(11, 64'h1);
      tick();
      rd(9, 64'h222, "rd_last_wins");
      exp_cfg[0]  = 64'h0000_0000_FFFF_FFFF;
      exp_cfg[2]  = 64'h0000_00FF_FFFF_FFFF;
      exp_cfg[3]  = 64'h1;
      exp_cfg[7]  = 64'h3;
      exp_cfg[9]  = 64'h222;
      exp_cfg[11] = 64'h1;
      chk_cfg_all("after_mask_tests");

      // Out-of-range writes and reads
      wr(N_REGS, 64'hDEAD);
      chk("oor_err_pulse", 64'(wr_err_o), 64'd1);
      chk("oor_no_commit", 64'(wr_ready_o), 64'd1);
      tick();
      chk("oor_err_drop", 64'(wr_err_o), 64'd0);
      wr(N_REGS + 3, 64'h7);
      chk("oor_flags_no_commit", 64'(wr_ready_o), 64'd1);
      tick();
      chk_cfg_all("oor_no_change");
      rd(N_REGS, 64'd0, "rd_oor_64");
      rd(2*N_REGS - 1, 64'd0, "rd_oor_127");

      // Clear on the same edge as the slice 3 flags update
      wr(12, 64'h55);
`ifdef RAB_SLICE_CFG_STAGING_EN
      wr(15, 64'h7);
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
`else
      clear_i = 1'b1;
      wr(15, 64'h7);
      clear_i = 1'b0;
`endif
      exp_cfg[3]  = 64'h0;
      exp_cfg[7]  = 64'h2;
      exp_cfg[11] = 64'h0;
      exp_cfg[12] = 64'h55;
      exp_cfg[15] = 64'h6;
      chk_cfg_all("clear_vs_commit");
      rd(11, 64'h0, "rd_slice2_cleared");
      rd(15, 64'h6, "rd_slice3_flags");

      // Reset while the slice 2 commit is pending
      wr(8, 64'h100);
      wr(11, 64'h5);
      Rst_RBI = 1'b0;
      #1;
      for (int i = 0; i < N_REGS; i++) exp_cfg[i] = 64'd0;
      chk("midrst_ready", 64'(wr_ready_o), 64'd1);
      chk("midrst_rd_valid", 64'(rd_valid_o), 64'd0);
      chk_cfg_all("midrst_cfg");
      tick();
      #2;
      Rst_RBI = 1'b1;
      tick();
      chk_cfg_all("after_midrst_cfg");
      rd(8, 64'd0, "rd_idx8_lost");
      rd(4, 64'd0, "rd_idx4_reset");
      wr(11, 64'h1);
      tick();
      rd(8, 64'd0, "rd_idx8_not_restaged");
      rd(11, 64'h1, "rd_idx11_flags");
      exp_cfg[11] = 64'h1;
      chk_cfg_all("final_cfg");

      tick();
      tick();
      chk("sb_drain", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
